// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator: next-PC select encoding
// and the default sequential increment.
package pc_pkg;

    localparam int PC_INC_DEFAULT = 4;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JREG   = 2'b10,
        PC_RET    = 2'b11
    } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. When full, a push overwrites the oldest entry.
// A simultaneous push and pop replaces the top entry in place.
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    w_ptrInc;
    logic [PW-1:0]    w_ptrDec;

    assign w_ptrInc = r_ptr + 1'b1;
    assign w_ptrDec = r_ptr - 1'b1;
    assign top      = r_mem[r_ptr];
    assign empty    = (r_count == '0);

    // r_ptr always names the top entry, so the slot after it is the oldest once full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (push && !pop) begin
            r_ptr <= w_ptrInc;
            if (r_count != CW'(DEPTH)) begin
                r_count <= r_count + 1'b1;
            end
        end else if (pop && !push) begin
            r_ptr   <= w_ptrDec;
            r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            if (pop) begin
                r_mem[r_ptr] <= push_data;
            end else begin
                r_mem[w_ptrInc] <= push_data;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with sequential, branch, jump-register and return
// targets. Misaligned targets are rejected. Macro PC_GEN_RAS_EN adds the return-address stack.
module pc_gen
    import pc_pkg::*;
#(
    parameter int                WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int                INC          = PC_INC_DEFAULT,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       pc_src,
    input  logic [WIDTH-1:0] imm_op,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic             call,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_inc,
    output logic             misalign,
    output logic             ras_empty
);

    pc_src_e          w_src;
    logic [WIDTH-1:0] r_pc;
    logic             r_misalign;
    logic [WIDTH-1:0] w_pcInc;
    logic [WIDTH-1:0] w_jregSum;
    logic [WIDTH-1:0] w_jreg;
    logic [WIDTH-1:0] w_nextPc;
    logic [WIDTH-1:0] w_rasTop;
    logic             w_rasEmpty;
    logic             w_rasHit;
    logic             w_badTarget;
    logic             w_accept;

    assign w_src       = pc_src_e'(pc_src);
    assign w_pcInc     = r_pc + WIDTH'(INC);
    assign w_jregSum   = rs1_data + imm_op;
    assign w_jreg      = {w_jregSum[WIDTH-1:1], 1'b0};
    assign w_rasHit    = (w_src == PC_RET) && !w_rasEmpty;
    assign w_badTarget = |w_nextPc[1:0];
    assign w_accept    = !stall && !w_badTarget;

    always_comb begin
        w_nextPc = w_pcInc;
        case (w_src)
            PC_SEQ:    w_nextPc = w_pcInc;
            PC_BRANCH: w_nextPc = r_pc + imm_op;
            PC_JREG:   w_nextPc = w_jreg;
            PC_RET:    w_nextPc = w_rasHit ? w_rasTop : w_jreg;
            default:   w_nextPc = w_pcInc;
        endcase
    end

    // A rejected target leaves pc in place and flags misalign for the following cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_VECTOR;
            r_misalign <= 1'b0;
        end else if (stall) begin
            r_misalign <= 1'b0;
        end else if (w_badTarget) begin
            r_misalign <= 1'b1;
        end else begin
            r_pc       <= w_nextPc;
            r_misalign <= 1'b0;
        end
    end

`ifdef PC_GEN_RAS_EN
    logic w_push;
    logic w_pop;

    assign w_push = !rst && w_accept && call;
    assign w_pop  = !rst && w_accept && w_rasHit;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pcInc),
        .top       (w_rasTop),
        .empty     (w_rasEmpty)
    );
`else
    logic        w_unusedCall;
    logic        w_unusedAccept;
    logic [31:0] w_unusedDepth;

    assign w_rasTop       = '0;
    assign w_rasEmpty     = 1'b1;
    assign w_unusedCall   = call;
    assign w_unusedAccept = w_accept;
    assign w_unusedDepth  = 32'(RAS_DEPTH);
`endif

    assign pc        = r_pc;
    assign pc_inc    = w_pcInc;
    assign misalign  = r_misalign;
    assign ras_empty = w_rasEmpty;

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC/immediate/register data width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-003 SHALL have parameter INC, default 4, sequential increment in bytes.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, number of return-address-stack entries; legal values are powers of two, at least 2.
REQ-005 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-006 SHALL have ports: rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have ports: stall  in  1  hold PC and all state this cycle.
REQ-008 SHALL have ports: pc_src  in  2  next-PC select: 00 sequential, 01 branch, 10 jump-register, 11 return.
REQ-009 SHALL have ports: imm_op  in  WIDTH  sign-extended immediate; rs1_data  in  WIDTH  register operand.
REQ-010 SHALL have ports: call  in  1  push the return address (PC+INC) on the RAS when the update is accepted.
REQ-011 SHALL have ports: pc  out  WIDTH  current PC; pc_inc  out  WIDTH  pc+INC, combinational.
REQ-012 SHALL have ports: misalign  out  1  registered, target rejected last cycle; ras_empty  out  1  RAS holds no entries.

Function
REQ-013 SHALL compute targets modulo 2^WIDTH with silent wrap-around: seq=pc+INC, branch=pc+imm_op, jreg=(rs1_data+imm_op) with bit 0 cleared.
REQ-014 SHALL, when stall=1, hold pc, the RAS pointer and the RAS count, clear misalign, and ignore pc_src and call.
REQ-015 SHALL, when stall=0, form next_pc from pc_src and load it into pc at the clock edge, one-cycle latency.
REQ-016 SHALL, when stall=0 and next_pc[1:0]!=0, leave pc unchanged, set misalign=1 for exactly that next cycle, and perform no RAS push or pop.
REQ-017 SHALL clear misalign on every non-stalled cycle whose target is aligned.
REQ-018 SHALL treat pc_src=11 as jump-register when RAS_EN is undefined or the RAS is empty.
REQ-019 SHALL, on an accepted return with the RAS non-empty, use the top entry as next_pc and pop it.
REQ-020 SHALL, on an accepted update with call=1, push pc+INC; when the RAS is full, overwrite the oldest entry (circular) and keep the count at RAS_DEPTH.
REQ-021 SHALL, on a simultaneous pop and push, take the popped value as the target and replace the top with pc+INC; the count is unchanged.
REQ-022 SHALL update ras_empty in the same cycle as the count changes; ras_empty is constant 1 without RAS_EN.

Reset
REQ-023 SHALL, when rst=1 at a rising edge, set pc=RESET_VECTOR, misalign=0, RAS count=0, pointer=0, ras_empty=1, overriding stall.
REQ-024 SHALL, when reset is asserted mid-call or mid-return, discard the push/pop of that cycle.
REQ-025 SHALL leave RAS entry contents unreset; they are unobservable while the count is 0.

Configuration
REQ-026 SHALL include the RAS only when macro PC_GEN_RAS_EN is defined; without it, no RAS storage exists, call is ignored, and pc_src=11 behaves as 10.

Structure
REQ-027 SHALL take the pc_src encoding enum (PC_SEQ, PC_BRANCH, PC_JREG, PC_RET) from the shared package pc_pkg, together with the default INC constant.
REQ-028 SHALL implement the RAS as sub-module pc_ras with push, pop, top and empty signals, instantiated only under PC_GEN_RAS_EN.

Verification
REQ-029 SHALL cover: reset with RESET_VECTOR=0x100, then 3 sequential cycles -> pc 0x100, 0x104, 0x108, 0x10C.
REQ-030 SHALL cover: pc=0x200, branch with imm_op=0xFFFFFFF0 -> pc=0x1F0; pc=0xFFFFFFFC sequential -> pc=0x0 (wrap).
REQ-031 SHALL cover: jump-register with rs1=0x301, imm=0 -> pc=0x300; branch with imm=0x2 from 0x300 -> pc stays 0x300 and misalign=1 for one cycle.
REQ-032 SHALL cover: stall=1 for 3 cycles with pc_src=01 and call=1 -> pc, RAS and ras_empty unchanged; misalign=0.
REQ-033 SHALL cover (RAS_EN, depth 4): 5 calls from pcs 0x10,0x20,0x30,0x40,0x50, then 5 returns -> targets 0x54,0x44,0x34,0x24, and the fifth return falls back to jump-register with ras_empty=1.
REQ-034 SHALL cover: rst asserted in the same cycle as a call at pc=0x80 -> pc=RESET_VECTOR, ras_empty=1, and the next return uses rs1_data+imm_op.
